// File: rtl/mult_pkg.sv
// Shared constants and the in-flight tag record for the multiplier scheduler.
package mult_pkg;

    localparam int unsigned DEF_W       = 8;
    localparam int unsigned DEF_PW      = 2 * DEF_W;
    localparam int unsigned DEF_LATENCY = 8;
    localparam int unsigned NREQ_MAX    = 8;
    localparam int unsigned TAG_IDW     = $clog2(NREQ_MAX);

    // One in-flight operand pair: valid flag plus the owning requester index.
    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves
// past the winner whenever the grant is taken.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned PW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_id
);

    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

    logic [PW-1:0] ptr;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // Search req from ptr upward, wrapping modulo NREQ; first set bit wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        if (!rst) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                sum = {1'b0, ptr} + (PW+1)'(i);
                if (sum >= NREQ_W) begin
                    sum = sum - NREQ_W;
                end
                idx = sum[PW-1:0];
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_id   = idx;
                end
            end
        end
    end

    // Pointer moves to the requester after the winner; idle cycles leave it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_id == PW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one pipelined signed multiplier between NREQ requesters. Operands are
// registered toward the multiplier together with an owner tag; the tag rides a
// LATENCY-deep shift register so it lines up with the product coming back.
module mult_rr_scheduler
    import mult_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = DEF_W,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_p,
    output logic [NREQ-1:0]   resp_valid,
    output logic [2*W-1:0]    resp_p,
    output logic              busy
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_id;
    logic            hs;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    tag_t            issue_tag;
    tag_t            tag_pipe [LATENCY];
    tag_t            last_tag;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (hs),
        .grant   (grant),
        .grant_id(grant_id)
    );

    assign req_ready = grant;
    assign hs        = |(req_valid & grant);
    assign last_tag  = tag_pipe[LATENCY-1];

    // Mux the winning requester's operands.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    // Issue register: winner's operands and tag, zeros on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a     <= '0;
            mul_b     <= '0;
            issue_tag <= '0;
        end else if (hs) begin
            mul_a           <= sel_a;
            mul_b           <= sel_b;
            issue_tag.valid <= 1'b1;
            issue_tag.id    <= TAG_IDW'(grant_id);
        end else begin
            mul_a     <= '0;
            mul_b     <= '0;
            issue_tag <= '0;
        end
    end

    // Tag pipe mirrors the multiplier depth; it never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Response register: route the product to its owner; hold data when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_p     <= '0;
        end else if (last_tag.valid) begin
            resp_valid <= NREQ'(1) << last_tag.id;
            resp_p     <= mul_p;
        end else begin
            resp_valid <= '0;
        end
    end

    // Busy while anything is in the issue register, the tag pipe or the response.
    always_comb begin
        busy = issue_tag.valid | (|resp_valid);
        for (int unsigned i = 0; i < LATENCY; i++) begin
            busy = busy | tag_pipe[i].valid;
        end
    end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench: two schedulers (LATENCY 8 and 2) share one stimulus stream and are
// checked every cycle against a behavioural model, plus directed vectors.
module tb_mult_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic [3:0]    rdy    [2];
    logic [7:0]    ma     [2];
    logic [7:0]    mb     [2];
    logic [15:0]   mp_out [2];
    logic [3:0]    rv     [2];
    logic [15:0]   rp     [2];
    logic          bsy    [2];

    always #5 clk = ~clk;

    mult_rr_scheduler #(.NREQ(4), .W(8), .LATENCY(8)) dut8 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(rdy[0]), .mul_a(ma[0]), .mul_b(mb[0]), .mul_p(mp_out[0]),
        .resp_valid(rv[0]), .resp_p(rp[0]), .busy(bsy[0]));

    mult_rr_scheduler #(.NREQ(4), .W(8), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(rdy[1]), .mul_a(ma[1]), .mul_b(mb[1]), .mul_p(mp_out[1]),
        .resp_valid(rv[1]), .resp_p(rp[1]), .busy(bsy[1]));

    // Behavioural mult8x8: LATENCY cycles from a/b edge to p, no reset.
    logic signed [15:0] mpipe [2][8];
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mpipe[k][0] <= $signed(ma[k]) * $signed(mb[k]);
            for (int s = 1; s < 8; s++) mpipe[k][s] <= mpipe[k][s-1];
        end
    end
    assign mp_out[0] = mpipe[0][7];
    assign mp_out[1] = mpipe[1][1];

    function automatic int lat(int k);
        return (k == 0) ? 8 : 2;
    endfunction

    // Model state
    typedef struct { int due; int dut; int id; int p; } pend_t;
    typedef struct { int id; int p; } resp_t;
    typedef struct { int id; int a; int b; int exp_p; } vec_t;

    pend_t      pend [$];
    resp_t      got  [$];
    int         m_ptr;
    int         edge_n;
    int         last_hs;
    logic [3:0] m_grant;
    logic [7:0] e_ma, e_mb;
    logic [3:0] e_rv [2];
    int         e_rp [2];
    logic [3:0] last_rdy8;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    function automatic logic [3:0] model_grant();
        if (rst) return 4'b0000;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (m_ptr + i) % NREQ;
            if (req_valid[j]) return 4'(1 << j);
        end
        return 4'b0000;
    endfunction

    // One clock: check grant before the edge, advance model, check outputs after.
    task automatic cycle();
        pend_t keep [$];
        #2;
        m_grant   = model_grant();
        last_rdy8 = rdy[0];
        chk("req_ready8", int'(rdy[0]), int'(m_grant));
        chk("req_ready2", int'(rdy[1]), int'(m_grant));
        @(posedge clk);
        edge_n++;
        if (rst) begin
            m_ptr   = 0;
            pend.delete();
            last_hs = -100;
            e_ma    = '0;
            e_mb    = '0;
            for (int k = 0; k < 2; k++) begin
                e_rv[k] = '0;
                e_rp[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) e_rv[k] = '0;
            keep.delete();
            foreach (pend[i]) begin
                if (pend[i].due == edge_n) begin
                    e_rv[pend[i].dut] = 4'(1 << pend[i].id);
                    e_rp[pend[i].dut] = pend[i].p;
                end else begin
                    keep.push_back(pend[i]);
                end
            end
            pend = keep;
            if (m_grant != 4'b0000) begin
                int g;
                int pa;
                int pb;
                g = 0;
                for (int i = 0; i < NREQ; i++) if (m_grant[i]) g = i;
                e_ma    = req_a[g*W +: W];
                e_mb    = req_b[g*W +: W];
                pa      = int'($signed(e_ma));
                pb      = int'($signed(e_mb));
                m_ptr   = (g + 1) % NREQ;
                last_hs = edge_n;
                for (int k = 0; k < 2; k++)
                    pend.push_back('{due: edge_n + lat(k) + 1, dut: k, id: g, p: pa * pb});
            end else begin
                e_ma = '0;
                e_mb = '0;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mul_a%0d", lat(k)), int'(ma[k]), int'(e_ma));
            chk($sformatf("mul_b%0d", lat(k)), int'(mb[k]), int'(e_mb));
            chk($sformatf("resp_valid%0d", lat(k)), int'(rv[k]), int'(e_rv[k]));
            chk($sformatf("resp_p%0d", lat(k)), int'($signed(rp[k])), e_rp[k]);
            chk($sformatf("busy%0d", lat(k)), int'(bsy[k]),
                (last_hs >= edge_n - lat(k) - 1) ? 1 : 0);
        end
        if (rv[0] != 4'b0000) begin
            int id;
            id = 0;
            for (int i = 0; i < NREQ; i++) if (rv[0][i]) id = i;
            got.push_back('{id: id, p: int'($signed(rp[0]))});
        end
        @(negedge clk);
    endtask

    task automatic clr();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic set_req(int i, int a, int b);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = a[7:0];
        req_b[i*W +: W]  = b[7:0];
    endtask

    task automatic drain(int n);
        clr();
        repeat (n) cycle();
    endtask

    vec_t tbl [9];
    int   exp4 [4];

    initial begin
        tbl[0] = '{0,   53,   27,   1431};
        tbl[1] = '{1,   17, -125,  -2125};
        tbl[2] = '{2,  -93,   75,  -6975};
        tbl[3] = '{3,  -47,  -83,   3901};
        tbl[4] = '{0,    0,    0,      0};
        tbl[5] = '{1, -128, -128,  16384};
        tbl[6] = '{2,  127, -128, -16256};
        tbl[7] = '{3,   -1,   -1,      1};
        tbl[8] = '{0,  127,  127,  16129};
        exp4   = '{-2125, -6975, 3901, 0};

        edge_n  = 0;
        m_ptr   = 0;
        last_hs = -100;
        rst     = 1'b1;
        clr();
        cycle();
        cycle();
        chk("reset_ready", int'(rdy[0]), 0);
        chk("reset_mul_a", int'(ma[0]), 0);
        chk("reset_resp_valid", int'(rv[0]), 0);
        chk("reset_resp_p", int'(rp[0]), 0);
        chk("reset_busy", int'(bsy[0]), 0);
        rst = 1'b0;
        cycle();

        // Table vectors: single op, response 9 cycles after handshake on LATENCY=8.
        for (int t = 0; t < 9; t++) begin
            clr();
            set_req(tbl[t].id, tbl[t].a, tbl[t].b);
            cycle();
            chk("tbl_grant", int'(last_rdy8), 1 << tbl[t].id);
            clr();
            repeat (8) cycle();
            chk("tbl_early8", int'(rv[0]), 0);
            cycle();
            chk("tbl_rv8", int'(rv[0]), 1 << tbl[t].id);
            chk("tbl_p8", int'($signed(rp[0])), tbl[t].exp_p);
            chk("tbl_p2_held", int'($signed(rp[1])), tbl[t].exp_p);
        end
        drain(2);

        // All four requesters at once after reset: grants 0,1,2,3 then ordered responses.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        got.delete();
        set_req(0, 17, -125);
        set_req(1, -93, 75);
        set_req(2, -47, -83);
        set_req(3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("all4_grant", int'(last_rdy8), 1 << i);
            req_valid[i] = 1'b0;
        end
        drain(12);
        chk("all4_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk("all4_id", got[i].id, i);
            chk("all4_p", got[i].p, exp4[i]);
        end

        // Pointer wrap: move pointer to 3, then req3 and req0 alternate.
        clr();
        set_req(2, 3, 3);
        cycle();
        clr();
        set_req(3, 2, 5);
        set_req(0, -4, 6);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("wrap_grant", int'(last_rdy8), (i % 2 == 0) ? 8 : 1);
        end
        drain(12);

        // Persistent single requester streams one result per cycle.
        clr();
        set_req(1, -128, -128);
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("stream_grant", int'(last_rdy8), 2);
            if (i >= 9) begin
                chk("stream_rv8", int'(rv[0]), 2);
                chk("stream_p8", int'($signed(rp[0])), 16384);
            end
        end
        drain(12);

        // Reset mid-flight: in-flight ops are dropped on the LATENCY=8 instance.
        clr();
        set_req(0, 5, 7);
        repeat (4) cycle();
        clr();
        repeat (2) cycle();
        chk("midrst_busy_before", int'(bsy[0]), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_busy_after8", int'(bsy[0]), 0);
        chk("midrst_busy_after2", int'(bsy[1]), 0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("midrst_noresp8", int'(rv[0]), 0);
        end
        set_req(0, 127, -128);
        cycle();
        clr();
        repeat (9) cycle();
        chk("midrst_next_rv8", int'(rv[0]), 1);
        chk("midrst_next_p8", int'($signed(rp[0])), -16256);

        // Idle: nothing moves, pointer (now 1) is kept.
        drain(12);
        chk("idle_mul_a", int'(ma[0]), 0);
        chk("idle_busy", int'(bsy[0]), 0);
        req_valid = 4'b1111;
        cycle();
        chk("idle_ptr_kept", int'(last_rdy8), 2);
        drain(12);

        // Random traffic with occasional resets against the model.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = 4'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            cycle();
        end
        rst = 1'b0;
        drain(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at edge %0d", edge_n);
        $fatal(1, "timeout");
    end

endmodule
